// File: rtl/cpu_cycle_sequencer.sv
// rtl/cpu_cycle_sequencer.sv - T-state / M-cycle timing generator with wait, halt and overrun handling
module cpu_cycle_sequencer #(
  parameter int STEPS   = 4,
  parameter int MCYCLES = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_IR_Fetch,
  input  logic               i_Wait,
  input  logic               i_Halt,
  output logic [STEPS-1:0]   o_Cycle_Step,
  output logic [MCYCLES-1:0] o_Cycle_Count,
  output logic               o_New_Instr,
  output logic               o_Halted,
  output logic               o_Overrun
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [STEPS-1:0]   STEP_T1  = STEPS'(1);
  localparam logic [MCYCLES-1:0] COUNT_M1 = MCYCLES'(1);

  state_t               state;
  state_t               state_nxt;
  logic [STEPS-1:0]     step_nxt;
  logic [MCYCLES-1:0]   count_nxt;
  logic                 new_instr_nxt;
  logic                 overrun_nxt;
  logic                 en;

  // A pending memory access freezes every register, so the whole update is gated by en.
  assign en = ~i_Wait;

  // Halted is a decode of the state flop, so it stays a registered output.
  assign o_Halted = (state == ST_HALTED);

  // Next-state and next-output computation; everything holds unless enabled.
  always_comb begin
    state_nxt     = state;
    step_nxt      = o_Cycle_Step;
    count_nxt     = o_Cycle_Count;
    new_instr_nxt = o_New_Instr;
    overrun_nxt   = o_Overrun;

    if (en) begin
      case (state)
        ST_HALTED: begin
          step_nxt      = STEP_T1;
          count_nxt     = COUNT_M1;
          new_instr_nxt = 1'b0;
          // Leaving HALT starts a fresh instruction at T1 without rotating the step.
          if (!i_Halt) begin
            state_nxt     = ST_RUN;
            new_instr_nxt = 1'b1;
          end
        end

        ST_RUN: begin
          new_instr_nxt = 1'b0;
          step_nxt      = {o_Cycle_Step[STEPS-2:0], o_Cycle_Step[STEPS-1]};
          // Fetch and halt only matter on the last T-state of an M-cycle.
          if (o_Cycle_Step[STEPS-1]) begin
            if (i_IR_Fetch) begin
              count_nxt = COUNT_M1;
              if (i_Halt) begin
                state_nxt = ST_HALTED;
              end else begin
                new_instr_nxt = 1'b1;
              end
            end else if (o_Cycle_Count[MCYCLES-1]) begin
              // Ran past the last M-cycle with no fetch: force a restart and flag it.
              count_nxt     = COUNT_M1;
              overrun_nxt   = 1'b1;
              new_instr_nxt = 1'b1;
            end else begin
              count_nxt = {o_Cycle_Count[MCYCLES-2:0], 1'b0};
            end
          end
        end

        default: begin
          state_nxt = ST_RUN;
        end
      endcase

      // Corrupted one-hot vectors snap back to their reset values.
      if (!$onehot(o_Cycle_Step)) begin
        step_nxt = STEP_T1;
      end
      if (!$onehot(o_Cycle_Count)) begin
        count_nxt = COUNT_M1;
      end
    end
  end

  // State and output registers; reset starts the first instruction immediately.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= ST_RUN;
      o_Cycle_Step  <= STEP_T1;
      o_Cycle_Count <= COUNT_M1;
      o_New_Instr   <= 1'b1;
      o_Overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_Cycle_Step  <= step_nxt;
      o_Cycle_Count <= count_nxt;
      o_New_Instr   <= new_instr_nxt;
      o_Overrun     <= overrun_nxt;
    end
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Timing generator for the CPU control unit. It produces the one-hot T-state strobe (`o_Cycle_Step`) and the one-hot M-cycle index (`o_Cycle_Count`) consumed by every per-instruction microcode block. It sits directly upstream of those blocks. It closes the loop on their OR-ed `IR_Fetch` output to restart the M-cycle count at each instruction boundary. It also handles memory wait-stretching, HALT parking and overrun detection.

## Interface
Parameters:
- `STEPS`, 4: T-states per M-cycle; width of `o_Cycle_Step`. Fixed at 4; no other value supported.
- `MCYCLES`, 8: maximum M-cycles per instruction; width of `o_Cycle_Count`.

Ports:
- `i_Clk`  in  1  system clock; all state changes on rising edge
- `i_Reset_n`  in  1  asynchronous active-low reset
- `i_IR_Fetch`  in  1  OR of all microcode `o_IR_Fetch`; high during the final M-cycle of the current instruction
- `i_Wait`  in  1  memory not ready; freezes sequencer state while high
- `i_Halt`  in  1  HALT request from decoder; sampled only at instruction boundary
- `o_Cycle_Step`  out  4  one-hot T-state, bit0 = T1
- `o_Cycle_Count`  out  8  one-hot M-cycle index, bit0 = first M-cycle
- `o_New_Instr`  out  1  high during T1 of the first M-cycle of each instruction
- `o_Halted`  out  1  sequencer parked in HALTED
- `o_Overrun`  out  1  sticky error: an instruction ran past M-cycle `MCYCLES-1` without `i_IR_Fetch`

## Operation
- State machine with two states, RUN and HALTED. Reset enters RUN.
- **Enable:** `en = ~i_Wait`. When `en` is 0, no register changes, including the FSM, outputs and `o_Overrun`.
- **RUN, step:** each enabled clock, `o_Cycle_Step` rotates left: 0001→0010→0100→1000→0001.
- **RUN, M-cycle end:** an M-cycle ends on an enabled clock with `o_Cycle_Step[3]=1`. At that edge:
  - If `i_IR_Fetch`=1 (boundary):
    - `o_Cycle_Count`←8'h01 and `o_New_Instr`←1.
    - If `i_Halt`=1 on the same edge, go to HALTED instead.
  - Else, if `o_Cycle_Count[MCYCLES-1]`=1:
    - `o_Cycle_Count`←8'h01, `o_Overrun`←1 (sticky), `o_New_Instr`←1.
  - Else, `o_Cycle_Count` shifts left by one.
- **`o_New_Instr`:** cleared on the next enabled clock after it is set. It is therefore high for exactly the T1 step when not stretched.
- **`i_IR_Fetch` / `i_Halt` sampling:** both are ignored except at the `o_Cycle_Step[3]` edge.
- **HALTED:**
  - `o_Cycle_Step`=0001, `o_Cycle_Count`=8'h01, `o_Halted`=1, `o_New_Instr`=0; held every clock.
  - On the first clock with `i_Halt`=0 (and `en`), return to RUN with `o_New_Instr`←1 and step 0001.
  - `o_Cycle_Step` does not rotate on that exit edge.
- **Invariants:** `o_Cycle_Step` and `o_Cycle_Count` are always exactly one-hot. Any non-one-hot value, which is unreachable, recovers to the reset value on the next clock.
- **Reset:** asynchronous and immediate, including mid-M-cycle and mid-HALT. All in-progress state is discarded.

## Timing
- **Reset values:**
  - `o_Cycle_Step`=4'b0001, `o_Cycle_Count`=8'h01
  - `o_New_Instr`=1 (the first instruction starts at reset release)
  - `o_Halted`=0, `o_Overrun`=0, state RUN
- All outputs are registered. No combinational path exists from inputs to outputs.
- One M-cycle takes 4 clocks with no waits. An N-M-cycle instruction takes 4N clocks from `o_New_Instr` to the next `o_New_Instr`.
- `i_Wait` stretches whichever step is current, one clock per asserted cycle. Wait asserted at step 1000 together with `i_IR_Fetch` defers the boundary decision until the wait clears. `i_IR_Fetch` is sampled on that later edge.
- Simultaneous boundary plus overrun condition (`i_IR_Fetch`=1 at count bit `MCYCLES-1`): treated as a normal boundary; `o_Overrun` is not set.
- HALT entry latency: HALTED is visible the clock after the boundary edge. Exit latency: `o_New_Instr`=1 one clock after `i_Halt` falls.

## Test plan
- **Reset release, `i_IR_Fetch` high from 4'b0100 of count 8'h04 onward:**
  - Step sequence 1,2,4,8 repeats.
  - Count goes 01,02,04, then 01 at clock 12.
  - `o_New_Instr` is high at clocks 0 and 12 only.
- **`i_Wait` held for 3 clocks during step 0010:**
  - Step stays 0010 for 4 clocks total.
  - Instruction length becomes 15 clocks.
  - No other output changes during the wait.
- **`i_IR_Fetch` never asserted:**
  - After 32 clocks, count wraps 80→01.
  - `o_Overrun`=1 and stays 1 until reset.
  - `o_New_Instr` pulses at the wrap.
- **`i_Halt`=1 with `i_IR_Fetch`=1 at the step-8 edge:**
  - `o_Halted`=1 next clock; step=0001, count=01 held.
  - Drop `i_Halt` → `o_Halted`=0 and `o_New_Instr`=1 one clock later.
- **`i_Halt` pulsed at a non-step-8 clock:** ignored; `o_Halted` stays 0.
- **`i_Reset_n` low at step 0100, count 8'h08 with `o_Overrun`=1:** outputs return to reset values asynchronously, before the next clock edge.
